// File: rtl/mmio_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mmio_pkg
// Purpose  : Shared constants for the MMIO device controller: default I/O
//            window base, register offsets within the window, the bit layout
//            of the per-device control registers, and helpers that compute
//            the next control state and its read-back word.
// Revision : 1.0 - initial release
// ============================================================================
package mmio_pkg;

    localparam logic [31:0] c_IO_BASE_DEFAULT = 32'hF000_0000;

    // Offsets are taken from address bits [27:0]; bits [1:0] are ignored
    localparam logic [27:0] c_OFF_HEX   = 28'h000;
    localparam logic [27:0] c_OFF_LEDR  = 28'h004;
    localparam logic [27:0] c_OFF_LEDG  = 28'h008;
    localparam logic [27:0] c_OFF_KDATA = 28'h010;
    localparam logic [27:0] c_OFF_SDATA = 28'h014;
    localparam logic [27:0] c_OFF_TCNT  = 28'h020;
    localparam logic [27:0] c_OFF_TLIM  = 28'h024;
    localparam logic [27:0] c_OFF_KCTRL = 28'h110;
    localparam logic [27:0] c_OFF_SCTRL = 28'h114;
    localparam logic [27:0] c_OFF_TCTL  = 28'h120;

    localparam int c_BIT_READY   = 0;
    localparam int c_BIT_OVERRUN = 2;
    localparam int c_BIT_IE      = 8;

    typedef struct packed {
        logic ie;
        logic ovr;
        logic ready;
    } ctrl_t;

    // An event always wins over a clearing read so it cannot be lost; in
    // that same cycle the overrun flag is left alone. An event also wins
    // over a software clear of overrun.
    function automatic ctrl_t ctrl_next(
        input ctrl_t cur,
        input logic  evt,
        input logic  clr_rd,
        input logic  wr,
        input logic  wr_ovr,
        input logic  wr_ie
    );
        ctrl_t nxt;
        nxt = cur;
        if (evt)
            nxt.ready = 1'b1;
        else if (clr_rd)
            nxt.ready = 1'b0;
        if (evt && cur.ready && !clr_rd)
            nxt.ovr = 1'b1;
        else if (wr && !wr_ovr)
            nxt.ovr = 1'b0;
        if (wr)
            nxt.ie = wr_ie;
        return nxt;
    endfunction

    function automatic logic [31:0] ctrl_word(input ctrl_t c);
        logic [31:0] w;
        w = '0;
        w[c_BIT_READY]   = c.ready;
        w[c_BIT_OVERRUN] = c.ovr;
        w[c_BIT_IE]      = c.ie;
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mmio_dev_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : mmio_dev_ctrl_if
// Purpose  : Data-memory-side bus between the pipeline and the MMIO
//            controller.
//            addr  - byte address      wrtEn - store strobe
//            rdEn  - load strobe       dIn   - store data
//            dOut  - read data         sel   - address hits the I/O window
// Revision : 1.0 - initial release
// ============================================================================
interface mmio_dev_ctrl_if #(
    parameter int DBITS = 32
);
    logic [DBITS-1:0] addr;
    logic             wrtEn;
    logic             rdEn;
    logic [DBITS-1:0] dIn;
    logic [DBITS-1:0] dOut;
    logic             sel;

    modport master (output addr, wrtEn, rdEn, dIn, input dOut, sel);
    modport slave  (input addr, wrtEn, rdEn, dIn, output dOut, sel);
endinterface
`default_nettype wire

// File: rtl/mmio_debounce.sv
`default_nettype none
// ============================================================================
// Module   : mmio_debounce
// Purpose  : Two-flop synchroniser followed by an optional stability filter.
//            With CYCLES <= 1 the synchronised value is passed straight
//            through and any bit change is an event.
//            clk, reset - clock, synchronous active-high reset
//            din        - raw asynchronous input
//            dout       - synchronised / debounced value
//            evt        - one-cycle pulse when dout is about to change
//                         (debounced) or has just changed (sync only)
// Revision : 1.0 - initial release
// ============================================================================
module mmio_debounce #(
    parameter int WIDTH  = 1,
    parameter int CYCLES = 1
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic [WIDTH-1:0] din,
    output logic      [WIDTH-1:0] dout,
    output logic                  evt
);

    logic [WIDTH-1:0] r_s1;
    logic [WIDTH-1:0] r_s2;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= din;
            r_s2 <= r_s1;
        end
    end

    generate
        if (CYCLES <= 1) begin : g_sync_only
            logic [WIDTH-1:0] r_prev;

            always_ff @(posedge clk) begin
                if (reset)
                    r_prev <= '0;
                else
                    r_prev <= r_s2;
            end

            assign dout = r_s2;
            assign evt  = (r_s2 != r_prev);
        end else begin : g_debounce
            localparam int c_CW = $clog2(CYCLES);

            logic [c_CW-1:0]  r_cnt;
            logic [WIDTH-1:0] r_cand;
            logic [WIDTH-1:0] r_out;
            logic             w_stable;

            assign w_stable = (r_s2 == r_cand) && (r_cnt == c_CW'(CYCLES - 1));
            // Counter saturates once stable; only a differing candidate commits
            assign evt      = w_stable && (r_cand != r_out);
            assign dout     = r_out;

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_cnt  <= '0;
                    r_cand <= '0;
                    r_out  <= '0;
                end else if (r_s2 != r_cand) begin
                    r_cand <= r_s2;
                    r_cnt  <= '0;
                end else if (!w_stable) begin
                    r_cnt  <= r_cnt + c_CW'(1);
                end else if (evt) begin
                    r_out  <= r_cand;
                end
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/mmio_dev_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mmio_dev_ctrl
// Purpose  : Memory-mapped I/O block for KEY/SW/HEX/LEDR/LEDG plus a tick
//            timer, with per-device ready/overrun/IE control registers and
//            an aggregate registered interrupt.
//            clk, reset - clock, synchronous active-high reset
//            bus        - data-memory bus (addr/wrtEn/rdEn/dIn/dOut/sel)
//            key        - raw push-buttons, active-low
//            sw         - raw slide switches
//            ledr, ledg - LED registers
//            hex        - seven-segment nibble register
//            intr       - interrupt request
// Revision : 1.0 - initial release
// ============================================================================
module mmio_dev_ctrl
    import mmio_pkg::*;
#(
    parameter int          DBITS           = 32,
    parameter int          KEY_BITS        = 4,
    parameter int          SW_BITS         = 10,
    parameter int          LEDR_BITS       = 10,
    parameter int          LEDG_BITS       = 8,
    parameter int          HEX_BITS        = 16,
    parameter int          DEBOUNCE_CYCLES = 500000,
    parameter int          TICK_CYCLES     = 50000,
    parameter logic [31:0] IO_BASE         = c_IO_BASE_DEFAULT
) (
    input  wire logic                 clk,
    input  wire logic                 reset,
    mmio_dev_ctrl_if.slave            bus,
    input  wire logic [KEY_BITS-1:0]  key,
    input  wire logic [SW_BITS-1:0]   sw,
    output logic      [LEDR_BITS-1:0] ledr,
    output logic      [LEDG_BITS-1:0] ledg,
    output logic      [HEX_BITS-1:0]  hex,
    output logic                      intr
);

    localparam int c_PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

    // ---------------- address decode ----------------
    logic [27:0] w_off;
    logic        w_sel;
    logic        w_wr;
    logic        w_rd;
    logic        w_unused_addr;

    assign w_sel         = (bus.addr[DBITS-1 -: 4] == IO_BASE[31:28]);
    assign w_off         = {bus.addr[27:2], 2'b00};
    assign w_wr          = bus.wrtEn & w_sel;
    assign w_rd          = bus.rdEn & w_sel;
    assign w_unused_addr = ^bus.addr[1:0];
    assign bus.sel       = w_sel;

    // ---------------- state ----------------
    logic [HEX_BITS-1:0]  r_hex;
    logic [LEDR_BITS-1:0] r_ledr;
    logic [LEDG_BITS-1:0] r_ledg;
    logic [DBITS-1:0]     r_tcnt;
    logic [DBITS-1:0]     r_tlim;
    logic [c_PW-1:0]      r_presc;
    ctrl_t                r_kctl;
    ctrl_t                r_sctl;
    ctrl_t                r_tctl;
    logic                 r_intr;

    assign hex  = r_hex;
    assign ledr = r_ledr;
    assign ledg = r_ledg;
    assign intr = r_intr;

    // ---------------- input paths ----------------
    logic [KEY_BITS-1:0] w_kdata;
    logic [SW_BITS-1:0]  w_sdata;
    logic                w_kevt;
    logic                w_sevt;

    mmio_debounce #(.WIDTH(KEY_BITS), .CYCLES(1)) u_key (
        .clk   (clk),
        .reset (reset),
        .din   (~key),
        .dout  (w_kdata),
        .evt   (w_kevt)
    );

    mmio_debounce #(.WIDTH(SW_BITS), .CYCLES(DEBOUNCE_CYCLES)) u_sw (
        .clk   (clk),
        .reset (reset),
        .din   (sw),
        .dout  (w_sdata),
        .evt   (w_sevt)
    );

    // ---------------- timer ----------------
    logic w_tick;
    logic w_twrap;
    logic w_tevt;
    logic w_wr_tcnt;
    logic w_wr_tlim;

    assign w_wr_tcnt = w_wr && (w_off == c_OFF_TCNT);
    assign w_wr_tlim = w_wr && (w_off == c_OFF_TLIM);
    assign w_tick    = (r_presc == c_PW'(TICK_CYCLES - 1));
    assign w_twrap   = (r_tlim != '0) && (r_tcnt == r_tlim - DBITS'(1));
    // A software TCNT write overrides the tick, so no wrap happens then
    assign w_tevt    = w_tick && w_twrap && !w_wr_tcnt;

    // ---------------- control strobes ----------------
    logic w_clr_k;
    logic w_clr_s;
    logic w_clr_t;
    logic w_wr_kctl;
    logic w_wr_sctl;
    logic w_wr_tctl;

    assign w_clr_k   = w_rd && (w_off == c_OFF_KDATA);
    assign w_clr_s   = w_rd && (w_off == c_OFF_SDATA);
    assign w_clr_t   = w_rd && (w_off == c_OFF_TCNT);
    assign w_wr_kctl = w_wr && (w_off == c_OFF_KCTRL);
    assign w_wr_sctl = w_wr && (w_off == c_OFF_SCTRL);
    assign w_wr_tctl = w_wr && (w_off == c_OFF_TCTL);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hex   <= '0;
            r_ledr  <= '0;
            r_ledg  <= '0;
            r_tcnt  <= '0;
            r_tlim  <= '0;
            r_presc <= '0;
            r_kctl  <= '0;
            r_sctl  <= '0;
            r_tctl  <= '0;
            r_intr  <= 1'b0;
        end else begin
            if (w_wr && (w_off == c_OFF_HEX))
                r_hex <= bus.dIn[HEX_BITS-1:0];
            if (w_wr && (w_off == c_OFF_LEDR))
                r_ledr <= bus.dIn[LEDR_BITS-1:0];
            if (w_wr && (w_off == c_OFF_LEDG))
                r_ledg <= bus.dIn[LEDG_BITS-1:0];

            if (w_wr_tlim || w_tick)
                r_presc <= '0;
            else
                r_presc <= r_presc + c_PW'(1);

            if (w_wr_tlim)
                r_tlim <= bus.dIn;

            if (w_wr_tcnt)
                r_tcnt <= bus.dIn;
            else if (w_tick)
                r_tcnt <= w_twrap ? '0 : r_tcnt + DBITS'(1);

            r_kctl <= ctrl_next(r_kctl, w_kevt, w_clr_k, w_wr_kctl,
                                bus.dIn[c_BIT_OVERRUN], bus.dIn[c_BIT_IE]);
            r_sctl <= ctrl_next(r_sctl, w_sevt, w_clr_s, w_wr_sctl,
                                bus.dIn[c_BIT_OVERRUN], bus.dIn[c_BIT_IE]);
            r_tctl <= ctrl_next(r_tctl, w_tevt, w_clr_t, w_wr_tctl,
                                bus.dIn[c_BIT_OVERRUN], bus.dIn[c_BIT_IE]);

            r_intr <= (r_kctl.ready & r_kctl.ie) |
                      (r_sctl.ready & r_sctl.ie) |
                      (r_tctl.ready & r_tctl.ie);
        end
    end

    // ---------------- read mux ----------------
    logic [DBITS-1:0] w_rdata;

    always_comb begin
        w_rdata = '0;
        case (w_off)
            c_OFF_HEX:   w_rdata = DBITS'(r_hex);
            c_OFF_LEDR:  w_rdata = DBITS'(r_ledr);
            c_OFF_LEDG:  w_rdata = DBITS'(r_ledg);
            c_OFF_KDATA: w_rdata = DBITS'(w_kdata);
            c_OFF_SDATA: w_rdata = DBITS'(w_sdata);
            c_OFF_TCNT:  w_rdata = r_tcnt;
            c_OFF_TLIM:  w_rdata = r_tlim;
            c_OFF_KCTRL: w_rdata = DBITS'(ctrl_word(r_kctl));
            c_OFF_SCTRL: w_rdata = DBITS'(ctrl_word(r_sctl));
            c_OFF_TCTL:  w_rdata = DBITS'(ctrl_word(r_tctl));
            default:     w_rdata = '0;
        endcase
        if (!w_sel)
            w_rdata = '0;
    end

    assign bus.dOut = w_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mmio_dev_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mmio_dev_ctrl
// Purpose  : Directed scoreboard bench for mmio_dev_ctrl with short debounce
//            (4) and tick (3) periods. Stimulus pushes expected values; a
//            negedge monitor pops and compares whenever a probe is raised.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mmio_dev_ctrl;

    localparam int c_SRC_DOUT = 0;
    localparam int c_SRC_LEDR = 1;
    localparam int c_SRC_LEDG = 2;
    localparam int c_SRC_HEX  = 3;
    localparam int c_SRC_INTR = 4;

    typedef struct {
        string       name;
        int          src;
        logic [31:0] exp;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [3:0]  key;
    logic [9:0]  sw;
    logic [9:0]  ledr;
    logic [7:0]  ledg;
    logic [15:0] hex;
    logic        intr;
    logic        probe;

    exp_t q[$];
    int   n_tests;
    int   n_fail;

    mmio_dev_ctrl_if #(.DBITS(32)) bus ();

    mmio_dev_ctrl #(
        .DBITS           (32),
        .KEY_BITS        (4),
        .SW_BITS         (10),
        .LEDR_BITS       (10),
        .LEDG_BITS       (8),
        .HEX_BITS        (16),
        .DEBOUNCE_CYCLES (4),
        .TICK_CYCLES     (3),
        .IO_BASE         (32'hF000_0000)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .key   (key),
        .sw    (sw),
        .ledr  (ledr),
        .ledg  (ledg),
        .hex   (hex),
        .intr  (intr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] act;
        if (probe) begin
            n_tests++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL monitor: probe with empty expectation queue, actual none required entry");
            end else begin
                e = q.pop_front();
                case (e.src)
                    c_SRC_DOUT: act = bus.dOut;
                    c_SRC_LEDR: act = {22'd0, ledr};
                    c_SRC_LEDG: act = {24'd0, ledg};
                    c_SRC_HEX:  act = {16'd0, hex};
                    default:    act = {31'd0, intr};
                endcase
                if (act !== e.exp) begin
                    n_fail++;
                    $display("FAIL %s: actual 0x%0h required 0x%0h", e.name, act, e.exp);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle_bus();
        bus.addr  = 32'h0;
        bus.dIn   = 32'h0;
        bus.wrtEn = 1'b0;
        bus.rdEn  = 1'b0;
        probe     = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) step();
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus.addr  = a;
        bus.dIn   = d;
        bus.wrtEn = 1'b1;
        step();
        idle_bus();
    endtask

    task automatic rd(input string nm, input logic [31:0] a,
                      input logic [31:0] e, input logic rden);
        bus.addr = a;
        bus.rdEn = rden;
        probe    = 1'b1;
        q.push_back('{nm, c_SRC_DOUT, e});
        step();
        idle_bus();
    endtask

    task automatic chk(input string nm, input int src, input logic [31:0] e);
        probe = 1'b1;
        q.push_back('{nm, src, e});
        step();
        idle_bus();
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, actual running required finished");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        n_tests = 0;
        n_fail  = 0;
        idle_bus();
        reset = 1'b1;
        key   = 4'hF;
        sw    = 10'h0;
        wait_cyc(2);
        reset = 1'b0;

        // reset state
        chk("rst_ledr", c_SRC_LEDR, 32'h0);
        chk("rst_ledg", c_SRC_LEDG, 32'h0);
        chk("rst_hex",  c_SRC_HEX,  32'h0);
        chk("rst_intr", c_SRC_INTR, 32'h0);
        rd("rst_kctrl", 32'hF000_0110, 32'h0, 1'b0);
        rd("rst_sctrl", 32'hF000_0114, 32'h0, 1'b0);
        rd("rst_tctl",  32'hF000_0120, 32'h0, 1'b0);

        // LED / HEX registers, width truncation, unmapped and off-window
        wr(32'hF000_0004, 32'h0000_03FF);
        chk("ledr_out", c_SRC_LEDR, 32'h3FF);
        rd("ledr_rd", 32'hF000_0004, 32'h3FF, 1'b1);
        wr(32'hF000_0030, 32'h0000_0123);
        chk("unmapped_ledr", c_SRC_LEDR, 32'h3FF);
        rd("unmapped_rd", 32'hF000_0030, 32'h0, 1'b1);
        wr(32'hF000_0000, 32'h0001_2345);
        chk("hex_out", c_SRC_HEX, 32'h2345);
        rd("hex_rd", 32'hF000_0000, 32'h2345, 1'b0);
        wr(32'hF000_0008, 32'h0000_01AB);
        chk("ledg_out", c_SRC_LEDG, 32'hAB);
        wr(32'h0000_0004, 32'h0000_0000);
        chk("nosel_ledr", c_SRC_LEDR, 32'h3FF);
        rd("nosel_rd", 32'h0000_0004, 32'h0, 1'b1);

        // KEY path
        key = 4'hE;
        wait_cyc(3);
        rd("kdata_1",  32'hF000_0010, 32'h1, 1'b0);
        rd("kctrl_rdy", 32'hF000_0110, 32'h1, 1'b0);
        key = 4'hC;
        wait_cyc(3);
        rd("kctrl_ovr", 32'hF000_0110, 32'h5, 1'b0);
        rd("kdata_3",  32'hF000_0010, 32'h3, 1'b0);
        wr(32'hF000_0110, 32'h0);
        rd("kctrl_ovr_clr", 32'hF000_0110, 32'h1, 1'b0);
        rd("kdata_clr_rd", 32'hF000_0010, 32'h3, 1'b1);
        rd("kctrl_after_rd", 32'hF000_0110, 32'h0, 1'b0);

        // SW debounce: a 3-cycle glitch must be rejected
        sw = 10'h1;
        wait_cyc(3);
        sw = 10'h0;
        wait_cyc(8);
        rd("sdata_glitch", 32'hF000_0014, 32'h0, 1'b0);
        rd("sctrl_glitch", 32'hF000_0114, 32'h0, 1'b0);
        sw = 10'h1;
        wait_cyc(10);
        rd("sdata_held",  32'hF000_0014, 32'h1, 1'b0);
        rd("sctrl_held",  32'hF000_0114, 32'h1, 1'b0);
        rd("sdata_clr_rd", 32'hF000_0014, 32'h1, 1'b1);
        rd("sctrl_after_rd", 32'hF000_0114, 32'h0, 1'b0);

        // Timer: every op below takes exactly one cycle; ticks land 3
        // cycles apart starting 3 edges after the TLIM write.
        wr(32'hF000_0024, 32'h2);
        wr(32'hF000_0020, 32'h0);
        rd("tcnt_a", 32'hF000_0020, 32'h0, 1'b0);
        rd("tcnt_b", 32'hF000_0020, 32'h0, 1'b0);
        rd("tcnt_c", 32'hF000_0020, 32'h1, 1'b0);
        rd("tcnt_d", 32'hF000_0020, 32'h1, 1'b0);
        rd("tcnt_e", 32'hF000_0020, 32'h1, 1'b0);
        rd("tcnt_wrap", 32'hF000_0020, 32'h0, 1'b0);
        rd("tctl_rdy", 32'hF000_0120, 32'h1, 1'b0);
        wr(32'hF000_0120, 32'h100);
        chk("intr_lag", c_SRC_INTR, 32'h0);
        chk("intr_set", c_SRC_INTR, 32'h1);
        // clearing read coincides with the next wrap
        rd("tcnt_rd_at_wrap", 32'hF000_0020, 32'h1, 1'b1);
        rd("tctl_simul", 32'hF000_0120, 32'h101, 1'b0);
        rd("tcnt_clr_rd", 32'hF000_0020, 32'h0, 1'b1);
        // TCNT write coincides with a tick
        wr(32'hF000_0020, 32'h55);
        rd("tcnt_wr_prio", 32'hF000_0020, 32'h55, 1'b0);
        rd("tctl_cleared", 32'hF000_0120, 32'h100, 1'b0);
        chk("intr_clr", c_SRC_INTR, 32'h0);
        rd("tcnt_inc", 32'hF000_0020, 32'h56, 1'b0);

        // reset mid-operation
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mid_rst_ledr", c_SRC_LEDR, 32'h0);
        chk("mid_rst_hex",  c_SRC_HEX,  32'h0);
        chk("mid_rst_intr", c_SRC_INTR, 32'h0);
        rd("mid_rst_tctl", 32'hF000_0120, 32'h0, 1'b0);
        rd("mid_rst_tlim", 32'hF000_0024, 32'h0, 1'b0);

        wait_cyc(2);
        if (q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: actual %0d pending expectations required 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
